// File: rtl/nanoproc_pkg.sv
// Shared types and constants for the accumulator nanoprocessor.
package nanoproc_pkg;

  localparam int OP_W = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_XOR = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SUB = 4'h6,
    OP_SBC = 4'h7,
    OP_ROL = 4'h8,
    OP_ROR = 4'h9,
    OP_LDA = 4'hA,
    OP_STA = 4'hB,
    OP_OUT = 4'hC,
    OP_JMP = 4'hD,
    OP_JNC = 4'hE,
    OP_JNZ = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_OPFETCH = 2'd2,
    ST_EXEC    = 2'd3
  } state_e;

endpackage

// File: rtl/nanoproc_if.sv
// Memory and output-port bundle between the core and board logic.
interface nanoproc_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              write;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  modport master (
    output addr, dout, write, out_data, out_valid,
    input  din
  );

  modport slave (
    input  addr, dout, write, out_data, out_valid,
    output din
  );
endinterface

// File: rtl/nanoproc_alu.sv
// Combinational ALU: logic, add/sub with carry, rotates through carry, load.
module nanoproc_alu
  import nanoproc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              zero
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] cin_ext_s;

  assign cin_ext_s = {{DATA_W{1'b0}}, c_in};

  // Compute the new accumulator and carry; subtraction borrow shows up as bit DATA_W.
  always_comb begin
    sum_s     = '0;
    result    = acc;
    carry_out = c_in;
    case (op)
      OP_XOR: result = acc ^ operand;
      OP_AND: result = acc & operand;
      OP_OR:  result = acc | operand;
      OP_ADD: begin
        sum_s = {1'b0, acc} + {1'b0, operand};
        {carry_out, result} = sum_s;
      end
      OP_ADC: begin
        sum_s = {1'b0, acc} + {1'b0, operand} + cin_ext_s;
        {carry_out, result} = sum_s;
      end
      OP_SUB: begin
        sum_s = {1'b0, acc} - {1'b0, operand};
        {carry_out, result} = sum_s;
      end
      OP_SBC: begin
        sum_s = {1'b0, acc} - {1'b0, operand} - cin_ext_s;
        {carry_out, result} = sum_s;
      end
      OP_ROL: {carry_out, result} = {acc, c_in};
      OP_ROR: {result, carry_out} = {c_in, acc};
      OP_LDA: result = operand;
      default: begin
        result    = acc;
        carry_out = c_in;
      end
    endcase
    zero = (result == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/nanoproc_core.sv
// Four-cycle accumulator nanoprocessor: FSM, PC, instruction, Acc, flags, output port.
module nanoproc_core
  import nanoproc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  nanoproc_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  opcode_e           ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] alu_res_s;
  logic              alu_c_s;
  logic              alu_z_s;
  logic [ADDR_W-1:0] jump_tgt_s;

  nanoproc_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (ir_q),
    .acc       (acc_q),
    .operand   (bus.din),
    .c_in      (c_q),
    .result    (alu_res_s),
    .carry_out (alu_c_s),
    .zero      (alu_z_s)
  );

  assign jump_tgt_s = bus.din[ADDR_W-1:0];

  // Next-state logic; nothing advances while en is low, and out_valid is a single-cycle pulse.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    c_d         = c_q;
    z_d         = z_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (en) begin
      case (state_q)
        ST_FETCH: state_d = ST_DECODE;
        ST_DECODE: begin
          ir_d    = opcode_e'(bus.din[OP_W-1:0]);
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_OPFETCH;
        end
        ST_OPFETCH: state_d = ST_EXEC;
        ST_EXEC: begin
          state_d = ST_FETCH;
          pc_d    = pc_q + ADDR_W'(1);
          case (ir_q)
            OP_XOR, OP_AND, OP_OR, OP_ADD, OP_ADC,
            OP_SUB, OP_SBC, OP_ROL, OP_ROR, OP_LDA: begin
              acc_d = alu_res_s;
              c_d   = alu_c_s;
              z_d   = alu_z_s;
            end
            OP_OUT: begin
              out_data_d  = acc_q;
              out_valid_d = 1'b1;
            end
            OP_JMP: pc_d = jump_tgt_s;
            OP_JNC: if (!c_q) pc_d = jump_tgt_s; else pc_d = pc_q + ADDR_W'(1);
            OP_JNZ: if (!z_q) pc_d = jump_tgt_s; else pc_d = pc_q + ADDR_W'(1);
            default: pc_d = pc_q + ADDR_W'(1);
          endcase
        end
        default: state_d = ST_FETCH;
      endcase
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= OP_NOP;
      acc_q       <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.addr      = pc_q;
  assign bus.dout      = acc_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  // STA writes Acc into its own operand slot; suppressed during reset or stall.
  assign bus.write     = (state_q == ST_OPFETCH) && (ir_q == OP_STA) && en && !reset;

endmodule

// File: tb/tb_nanoproc_core.sv
// Directed-vector bench for nanoproc_core (8-bit instance plus a 16-bit instance).
module tb_nanoproc_core;
  import nanoproc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic reset_w = 1'b1;
  logic en_w = 1'b0;

  logic        ld8 = 1'b0;
  logic        ld16 = 1'b0;
  logic [7:0]  ld_addr = 8'h00;
  logic [15:0] ld_data = 16'h0000;

  logic [7:0]  mem8  [256];
  logic [15:0] mem16 [256];
  logic [7:0]  rd8;
  logic [15:0] rd16;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  nanoproc_if #(.DATA_W(8),  .ADDR_W(8)) bus8 ();
  nanoproc_if #(.DATA_W(16), .ADDR_W(8)) bus16 ();

  nanoproc_core #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .bus(bus8.master)
  );

  nanoproc_core #(.DATA_W(16), .ADDR_W(8)) dut_w (
    .clk(clk), .reset(reset_w), .en(en_w), .bus(bus16.master)
  );

  // Synchronous 1-cycle-latency RAM models with a bench load port.
  always @(posedge clk) begin
    if (bus8.write) mem8[bus8.addr] <= bus8.dout;
    else if (ld8) mem8[ld_addr] <= ld_data[7:0];
    rd8 <= mem8[bus8.addr];
    if (bus16.write) mem16[bus16.addr] <= bus16.dout;
    else if (ld16) mem16[ld_addr] <= ld_data;
    rd16 <= mem16[bus16.addr];
  end
  assign bus8.din  = rd8;
  assign bus16.din = rd16;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [7:0] a, input logic [15:0] d, input logic wide);
    ld_addr = a; ld_data = d; ld8 = !wide; ld16 = wide;
    tick(1);
    ld8 = 1'b0; ld16 = 1'b0;
  endtask

  task automatic release_reset;
    reset = 1'b1; en = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1;
    tick(2);
    n_vec++; if (bus8.write !== 1'b0) begin n_miss++; $display("FAIL reset_write: got %0b expected 0", bus8.write); end
    reset = 1'b0;
    n_vec++; if (bus8.addr !== 8'h00) begin n_miss++; $display("FAIL reset_pc: got %0h expected 00", bus8.addr); end
    n_vec++; if (bus8.dout !== 8'h00) begin n_miss++; $display("FAIL reset_acc: got %0h expected 00", bus8.dout); end
    n_vec++; if (bus8.out_valid !== 1'b0 || bus8.out_data !== 8'h00) begin n_miss++; $display("FAIL reset_out: got %0b/%0h expected 0/00", bus8.out_valid, bus8.out_data); end
    n_vec++; if (dut.state_q !== ST_FETCH) begin n_miss++; $display("FAIL reset_state: got %0d expected 0", dut.state_q); end
    n_vec++; if ({dut.c_q, dut.z_q} !== 2'b00) begin n_miss++; $display("FAIL reset_flags: got %0b expected 00", {dut.c_q, dut.z_q}); end
    n_vec++; if (dut.ir_q !== OP_NOP) begin n_miss++; $display("FAIL reset_ir: got %0h expected 0", dut.ir_q); end
  endtask

  task automatic load_regression;
    reset = 1'b1;
    ld(8'd0, 16'hA, 1'b0);  ld(8'd1, 16'd3, 1'b0);
    ld(8'd2, 16'h4, 1'b0);  ld(8'd3, 16'd4, 1'b0);
    ld(8'd4, 16'h6, 1'b0);  ld(8'd5, 16'd1, 1'b0);
    ld(8'd6, 16'h1, 1'b0);  ld(8'd7, 16'd3, 1'b0);
    ld(8'd8, 16'h2, 1'b0);  ld(8'd9, 16'd11, 1'b0);
    ld(8'd10, 16'h3, 1'b0); ld(8'd11, 16'd24, 1'b0);
    ld(8'd12, 16'hB, 1'b0); ld(8'd13, 16'd0, 1'b0);
    ld(8'd14, 16'hD, 1'b0); ld(8'd15, 16'd14, 1'b0);
  endtask

  task automatic test_regression;
    load_regression();
    release_reset();
    tick(28);
    n_vec++; if (mem8[13] !== 8'd25) begin n_miss++; $display("FAIL regr_mem13: got %0d expected 25", mem8[13]); end
    n_vec++; if (bus8.dout !== 8'd25) begin n_miss++; $display("FAIL regr_acc: got %0d expected 25", bus8.dout); end
    n_vec++; if (dut.z_q !== 1'b0) begin n_miss++; $display("FAIL regr_z: got %0b expected 0", dut.z_q); end
    n_vec++; if (bus8.addr !== 8'd14 || dut.state_q !== ST_FETCH) begin n_miss++; $display("FAIL regr_pc: got %0d/%0d expected 14/0", bus8.addr, dut.state_q); end
  endtask

  task automatic test_carry;
    reset = 1'b1;
    ld(8'd0, 16'hA, 1'b0); ld(8'd1, 16'd200, 1'b0);
    ld(8'd2, 16'h4, 1'b0); ld(8'd3, 16'd100, 1'b0);
    ld(8'd4, 16'h5, 1'b0); ld(8'd5, 16'd0, 1'b0);
    ld(8'd6, 16'hD, 1'b0); ld(8'd7, 16'd6, 1'b0);
    release_reset();
    tick(8);
    n_vec++; if (bus8.dout !== 8'd44 || dut.c_q !== 1'b1) begin n_miss++; $display("FAIL carry_add: got %0d c=%0b expected 44 c=1", bus8.dout, dut.c_q); end
    tick(4);
    n_vec++; if (bus8.dout !== 8'd45 || dut.c_q !== 1'b0) begin n_miss++; $display("FAIL carry_adc: got %0d c=%0b expected 45 c=0", bus8.dout, dut.c_q); end
  endtask

  task automatic test_borrow;
    reset = 1'b1;
    ld(8'd0, 16'hA, 1'b0); ld(8'd1, 16'd1, 1'b0);
    ld(8'd2, 16'h6, 1'b0); ld(8'd3, 16'd2, 1'b0);
    ld(8'd4, 16'h7, 1'b0); ld(8'd5, 16'd0, 1'b0);
    ld(8'd6, 16'hD, 1'b0); ld(8'd7, 16'd6, 1'b0);
    release_reset();
    tick(8);
    n_vec++; if (bus8.dout !== 8'd255 || dut.c_q !== 1'b1 || dut.z_q !== 1'b0) begin n_miss++; $display("FAIL borrow_sub: got %0d c=%0b z=%0b expected 255 c=1 z=0", bus8.dout, dut.c_q, dut.z_q); end
    tick(4);
    n_vec++; if (bus8.dout !== 8'd254 || dut.c_q !== 1'b0) begin n_miss++; $display("FAIL borrow_sbc: got %0d c=%0b expected 254 c=0", bus8.dout, dut.c_q); end
  endtask

  task automatic test_rotate;
    reset = 1'b1;
    ld(8'd0, 16'hA, 1'b0); ld(8'd1, 16'h81, 1'b0);
    ld(8'd2, 16'h8, 1'b0); ld(8'd3, 16'h55, 1'b0);
    ld(8'd4, 16'h9, 1'b0); ld(8'd5, 16'hAA, 1'b0);
    ld(8'd6, 16'hA, 1'b0); ld(8'd7, 16'h00, 1'b0);
    ld(8'd8, 16'hD, 1'b0); ld(8'd9, 16'd8, 1'b0);
    release_reset();
    tick(8);
    n_vec++; if (bus8.dout !== 8'h02 || dut.c_q !== 1'b1) begin n_miss++; $display("FAIL rot_rol: got %0h c=%0b expected 02 c=1", bus8.dout, dut.c_q); end
    tick(4);
    n_vec++; if (bus8.dout !== 8'h81 || dut.c_q !== 1'b0) begin n_miss++; $display("FAIL rot_ror: got %0h c=%0b expected 81 c=0", bus8.dout, dut.c_q); end
    tick(4);
    n_vec++; if (bus8.dout !== 8'h00 || dut.z_q !== 1'b1) begin n_miss++; $display("FAIL rot_lda0: got %0h z=%0b expected 00 z=1", bus8.dout, dut.z_q); end
  endtask

  task automatic test_loop;
    int pulses = 0;
    int pulse_cyc = -1;
    logic [7:0] pulse_data = 8'hFF;
    logic [7:0] pulse_pc = 8'hFF;
    reset = 1'b1;
    ld(8'd0, 16'hA, 1'b0); ld(8'd1, 16'd3, 1'b0);
    ld(8'd2, 16'h6, 1'b0); ld(8'd3, 16'd1, 1'b0);
    ld(8'd4, 16'hF, 1'b0); ld(8'd5, 16'd2, 1'b0);
    ld(8'd6, 16'hC, 1'b0); ld(8'd7, 16'h99, 1'b0);
    ld(8'd8, 16'hD, 1'b0); ld(8'd9, 16'd8, 1'b0);
    release_reset();
    for (int i = 1; i <= 44; i++) begin
      tick(1);
      if (bus8.out_valid) begin
        pulses++;
        pulse_cyc = i;
        pulse_data = bus8.out_data;
        pulse_pc = bus8.addr;
      end
    end
    n_vec++; if (pulses !== 1) begin n_miss++; $display("FAIL loop_pulses: got %0d expected 1", pulses); end
    n_vec++; if (pulse_cyc !== 32) begin n_miss++; $display("FAIL loop_pulse_cycle: got %0d expected 32", pulse_cyc); end
    n_vec++; if (pulse_data !== 8'h00) begin n_miss++; $display("FAIL loop_out_data: got %0h expected 00", pulse_data); end
    n_vec++; if (pulse_pc !== 8'd8) begin n_miss++; $display("FAIL loop_pc_after: got %0d expected 8", pulse_pc); end
  endtask

  task automatic test_reset_mid_sta;
    reset = 1'b1;
    ld(8'd0, 16'hA, 1'b0); ld(8'd1, 16'd5, 1'b0);
    ld(8'd2, 16'hB, 1'b0); ld(8'd3, 16'h77, 1'b0);
    ld(8'd4, 16'hD, 1'b0); ld(8'd5, 16'd4, 1'b0);
    release_reset();
    tick(6);
    n_vec++; if (bus8.write !== 1'b1 || dut.state_q !== ST_OPFETCH) begin n_miss++; $display("FAIL sta_write_pre: got %0b/%0d expected 1/2", bus8.write, dut.state_q); end
    reset = 1'b1;
    #1;
    n_vec++; if (bus8.write !== 1'b0) begin n_miss++; $display("FAIL sta_write_in_reset: got %0b expected 0", bus8.write); end
    tick(1);
    reset = 1'b0;
    n_vec++; if (mem8[3] !== 8'h77) begin n_miss++; $display("FAIL sta_no_write: got %0h expected 77", mem8[3]); end
    n_vec++; if (bus8.addr !== 8'd0 || bus8.dout !== 8'd0) begin n_miss++; $display("FAIL sta_reset_state: got pc=%0d acc=%0d expected 0/0", bus8.addr, bus8.dout); end
  endtask

  task automatic test_en_toggle;
    load_regression();
    release_reset();
    for (int i = 0; i < 56; i++) begin
      en = (i % 2 == 0);
      tick(1);
      if (i == 27) begin
        n_vec++; if (bus8.addr !== 8'd7 || dut.state_q !== ST_OPFETCH) begin n_miss++; $display("FAIL en_midpoint: got pc=%0d st=%0d expected 7/2", bus8.addr, dut.state_q); end
      end
    end
    en = 1'b1;
    n_vec++; if (mem8[13] !== 8'd25 || bus8.dout !== 8'd25) begin n_miss++; $display("FAIL en_final: got mem=%0d acc=%0d expected 25/25", mem8[13], bus8.dout); end
    n_vec++; if (bus8.addr !== 8'd14 || dut.state_q !== ST_FETCH || dut.z_q !== 1'b0) begin n_miss++; $display("FAIL en_final_pc: got %0d st=%0d z=%0b expected 14/0/0", bus8.addr, dut.state_q, dut.z_q); end
  endtask

  task automatic test_wide;
    reset_w = 1'b1; en_w = 1'b1;
    ld(8'd0, 16'hA, 1'b1); ld(8'd1, 16'd1, 1'b1);
    ld(8'd2, 16'h4, 1'b1); ld(8'd3, 16'hFFFF, 1'b1);
    ld(8'd4, 16'hD, 1'b1); ld(8'd5, 16'd4, 1'b1);
    tick(1);
    reset_w = 1'b0;
    tick(8);
    n_vec++; if (bus16.dout !== 16'h0000 || dut_w.c_q !== 1'b1 || dut_w.z_q !== 1'b1) begin n_miss++; $display("FAIL wide_add: got %0h c=%0b z=%0b expected 0000 c=1 z=1", bus16.dout, dut_w.c_q, dut_w.z_q); end
  endtask

  initial begin
    test_reset();
    test_regression();
    test_carry();
    test_borrow();
    test_rotate();
    test_loop();
    test_reset_mid_sta();
    test_en_toggle();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
